// File: rtl/ipic_lite_arbiter.sv
// ipic_lite_arbiter
//   Shares the single IPIC-lite register-access port between NUM_REQ
//   requesters. Round-robin selection, one transaction in flight, waits for
//   the IPIC engine to go idle, issues a one-cycle start pulse and returns
//   done/err to the granted requester. A saturating per-transaction timeout
//   keeps a hung IPIC engine from locking everyone out.
//
// Ports
//   clk, reset             : clock, async active-high reset
//   req_valid/write        : per-requester request (held until done/err), 1=write
//   req_addr/req_wdata     : flattened per-requester command, requester i at [i*W +: W]
//   req_grant              : one-hot, high for the whole granted transaction
//   req_done / req_err     : one-cycle completion / timeout pulse to the granted requester
//   req_rdata              : last read data, updated on read completion only
//   curr_ipic_lite_state   : IPIC FSM state, 0 = idle
//   ipic_done_lite_wire    : IPIC completion pulse, single_read_data_lite valid with it
//   ipic_start_lite        : one-cycle start pulse
//   ipic_type_lite         : 2 = SINGLE_RD, 3 = SINGLE_WR
//   read/write_addr_lite, write_data_lite : command towards the IPIC engine
//   busy                   : arbiter not in IDLE
module ipic_lite_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_err,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  input  logic [3:0]                       curr_ipic_lite_state,
  input  logic                             ipic_done_lite_wire,
  input  logic [DATA_WIDTH-1:0]            single_read_data_lite,
  output logic                             ipic_start_lite,
  output logic [2:0]                       ipic_type_lite,
  output logic [ADDR_WIDTH-1:0]            read_addr_lite,
  output logic [ADDR_WIDTH-1:0]            write_addr_lite,
  output logic [DATA_WIDTH-1:0]            write_data_lite,
  output logic                             busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] CNT_TERM = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQ - 1);
  localparam logic [2:0] TYPE_RD = 3'd2;
  localparam logic [2:0] TYPE_WR = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IP, S_WAIT_DONE, S_RELEASE} state_t;

  state_t                r_state, w_next;
  logic [IDXW-1:0]       r_rr_ptr, r_idx, w_sel;
  logic                  w_any;
  logic [NUM_REQ-1:0]    w_onehot;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNTW-1:0]       r_cnt;
  logic                  w_ip_idle, w_term;

  assign w_ip_idle = (curr_ipic_lite_state == 4'd0);
  assign w_term    = (r_cnt == CNT_TERM);
  assign busy      = (r_state != S_IDLE);

  // Round-robin pick: walk from the highest offset down so the last hit
  // is the first requester at or after r_rr_ptr (wrapping).
  always_comb begin
    w_any    = 1'b0;
    w_sel    = '0;
    w_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_sel = IDXW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
    w_onehot[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any) w_next = S_WAIT_IP;
      S_WAIT_IP:   if (w_ip_idle) w_next = S_WAIT_DONE;
      // done is checked first so a done on the terminal count wins
      S_WAIT_DONE: if (ipic_done_lite_wire || w_term) w_next = S_RELEASE;
      S_RELEASE:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr        <= '0;
      r_idx           <= '0;
      r_write         <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_cnt           <= '0;
      req_grant       <= '0;
      req_done        <= '0;
      req_err         <= '0;
      req_rdata       <= '0;
      ipic_start_lite <= 1'b0;
      ipic_type_lite  <= '0;
      read_addr_lite  <= '0;
      write_addr_lite <= '0;
      write_data_lite <= '0;
    end else begin
      ipic_start_lite <= 1'b0;
      req_done        <= '0;
      req_err         <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          // command is frozen here; later requester changes are ignored
          r_idx     <= w_sel;
          r_write   <= req_write[w_sel];
          r_addr    <= req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
          r_wdata   <= req_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
          req_grant <= w_onehot;
        end
        S_WAIT_IP: if (w_ip_idle) begin
          ipic_start_lite <= 1'b1;
          ipic_type_lite  <= r_write ? TYPE_WR : TYPE_RD;
          read_addr_lite  <= r_addr;
          write_addr_lite <= r_addr;
          if (r_write) write_data_lite <= r_wdata;
          r_cnt <= '0;
        end
        S_WAIT_DONE: begin
          if (ipic_done_lite_wire) begin
            req_done[r_idx] <= 1'b1;
            if (!r_write) req_rdata <= single_read_data_lite;
          end else if (w_term) begin
            req_err[r_idx] <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          req_grant <= '0;
          r_rr_ptr  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipic_lite_arbiter.sv
// Bench for ipic_lite_arbiter: scoreboard of expected starts and completions,
// pushed when requests are driven, popped by a monitor on the falling edge.
module tb_ipic_lite_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_grant, req_done, req_err;
  logic [DW-1:0]     req_rdata;
  logic [3:0]        curr_ipic_lite_state;
  logic              ipic_done_lite_wire;
  logic [DW-1:0]     single_read_data_lite;
  logic              ipic_start_lite;
  logic [2:0]        ipic_type_lite;
  logic [AW-1:0]     read_addr_lite, write_addr_lite;
  logic [DW-1:0]     write_data_lite;
  logic              busy;

  ipic_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .curr_ipic_lite_state(curr_ipic_lite_state), .ipic_done_lite_wire(ipic_done_lite_wire),
    .single_read_data_lite(single_read_data_lite), .ipic_start_lite(ipic_start_lite),
    .ipic_type_lite(ipic_type_lite), .read_addr_lite(read_addr_lite),
    .write_addr_lite(write_addr_lite), .write_data_lite(write_data_lite), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [NR-1:0] gnt;
    logic [2:0]    typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } st_t;

  typedef struct {
    logic [NR-1:0] done;
    logic [NR-1:0] err;
    logic          rd;
    logic [DW-1:0] rdata;
  } cp_t;

  st_t exp_st[$];
  cp_t exp_cp[$];

  function automatic logic [NR-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  // to=1: transaction expected to end in req_err; rd = expected read data
  task automatic push(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic to, input logic [DW-1:0] rd);
    st_t s;
    cp_t c;
    s.gnt = oh(i); s.typ = wr ? 3'd3 : 3'd2; s.addr = a; s.wdata = d; s.wr = wr;
    exp_st.push_back(s);
    c.done = to ? '0 : oh(i); c.err = to ? oh(i) : '0; c.rd = !wr && !to; c.rdata = rd;
    exp_cp.push_back(c);
  endtask

  // wait for a start pulse; if lat >= 0 return done lat cycles after start
  task automatic serve(input int lat, input logic [DW-1:0] rd);
    int n = 0;
    while (ipic_start_lite !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    chk("start_seen", ipic_start_lite, 1);
    if (lat >= 0) begin
      tick(lat);
      single_read_data_lite = rd;
      ipic_done_lite_wire = 1'b1;
      tick(1);
      ipic_done_lite_wire = 1'b0;
      single_read_data_lite = '0;
      chk("done_lat", req_done != 0, 1);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {req_grant, req_done, req_err, ipic_start_lite, ipic_type_lite, busy}, 0);
    chk({tag, "_addr"}, {read_addr_lite, write_addr_lite}, 0);
    chk({tag, "_data"}, {req_rdata, write_data_lite}, 0);
  endtask

  // monitor: compares every start and every completion against the scoreboard
  initial begin : mon
    st_t s;
    cp_t c;
    logic in_flight;
    in_flight = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) in_flight = 1'b0;
      if (ipic_start_lite === 1'b1) begin
        chk("start_overlap", in_flight, 0);
        in_flight = 1'b1;
        chk("start_q", exp_st.size() != 0, 1);
        if (exp_st.size() != 0) begin
          s = exp_st.pop_front();
          chk("start_gnt", req_grant, s.gnt);
          chk("start_type", ipic_type_lite, s.typ);
          chk("start_raddr", read_addr_lite, s.addr);
          chk("start_waddr", write_addr_lite, s.addr);
          if (s.wr) chk("start_wdata", write_data_lite, s.wdata);
        end
      end
      if ((req_done | req_err) != 0) begin
        in_flight = 1'b0;
        chk("cpl_q", exp_cp.size() != 0, 1);
        if (exp_cp.size() != 0) begin
          c = exp_cp.pop_front();
          chk("cpl_done", req_done, c.done);
          chk("cpl_err", req_err, c.err);
          if (c.rd) chk("cpl_rdata", req_rdata, c.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : main
    logic seen;
    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    curr_ipic_lite_state = '0; ipic_done_lite_wire = 1'b0; single_read_data_lite = '0;
    tick(2);
    check_zero("rst");
    reset = 1'b0;
    tick(1);

    // single write on requester 1, done 3 cycles after start
    push(1, 1'b1, 32'h60000818, 32'hDEADBEEF, 1'b0, '0);
    req(1, 1'b1, 32'h60000818, 32'hDEADBEEF);
    tick(1);
    chk("t1_gnt", req_grant, 4'b0010);
    chk("t1_busy", busy, 1);
    chk("t1_nostart", ipic_start_lite, 0);
    tick(1);
    chk("t1_start", ipic_start_lite, 1);
    serve(3, '0);
    chk("t1_gnt_hold", req_grant, 4'b0010);
    req_valid[1] = 1'b0;
    tick(1);
    chk("t1_gnt_rel", req_grant, 0);
    chk("t1_idle", busy, 0);

    // single read on requester 0
    push(0, 1'b0, 32'h60000804, '0, 1'b0, 32'h12345678);
    req(0, 1'b0, 32'h60000804, '0);
    serve(2, 32'h12345678);
    chk("t2_rdata", req_rdata, 32'h12345678);
    req_valid[0] = 1'b0;
    tick(1);

    // a write completion must leave req_rdata alone
    push(3, 1'b1, 32'h6000080C, 32'h55AA55AA, 1'b0, '0);
    req(3, 1'b1, 32'h6000080C, 32'h55AA55AA);
    serve(1, 32'hFFFFFFFF);
    chk("t2_rd_hold", req_rdata, 32'h12345678);
    req_valid[3] = 1'b0;
    tick(1);

    // contention from reset: grant order 0,1,2,3,0
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++)
      push(k % NR, 1'b1, 32'h60000100 + 32'(k % NR) * 4, 32'hC0DE0000 + 32'(k % NR), 1'b0, '0);
    for (int i = 0; i < NR; i++)
      req(i, 1'b1, 32'h60000100 + 32'(i) * 4, 32'hC0DE0000 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      serve(3, '0);
      if (k == 4) begin
        req_valid = '0;
      end else begin
        tick(1);
        chk("t3_gap", req_grant, 0);
        tick(1);
        chk("t3_gnt", req_grant, oh((k + 1) % NR));
      end
    end
    tick(3);
    chk("t3_idle", busy, 0);

    // IPIC engine busy for 10 cycles after grant
    curr_ipic_lite_state = 4'd5;
    push(2, 1'b0, 32'h60000820, '0, 1'b0, 32'hCAFEF00D);
    req(2, 1'b0, 32'h60000820, '0);
    tick(1);
    chk("t4_gnt", req_grant, 4'b0100);
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      seen = seen | ipic_start_lite;
    end
    chk("t4_held", seen, 0);
    curr_ipic_lite_state = 4'd0;
    chk("t4_pre", ipic_start_lite, 0);
    tick(1);
    chk("t4_start", ipic_start_lite, 1);
    serve(2, 32'hCAFEF00D);
    req_valid[2] = 1'b0;
    tick(1);

    // timeout on requester 3, then requester 0 (pointer wraps 3 -> 0)
    push(3, 1'b1, 32'h60000830, 32'h0BADF00D, 1'b1, '0);
    push(0, 1'b0, 32'h60000834, '0, 1'b0, 32'h600DD00D);
    req(3, 1'b1, 32'h60000830, 32'h0BADF00D);
    req(0, 1'b0, 32'h60000834, '0);
    serve(-1, '0);
    seen = 1'b0;
    repeat (TO - 1) begin
      tick(1);
      seen = seen | (|(req_done | req_err));
    end
    chk("t5_quiet", seen, 0);
    tick(1);
    chk("t5_err", req_err, 4'b1000);
    chk("t5_nodone", req_done, 0);
    req_valid[3] = 1'b0;
    tick(1);
    chk("t5_gap", req_grant, 0);
    tick(1);
    chk("t5_next", req_grant, 4'b0001);
    // done on the terminal count: done wins
    serve(TO - 1, 32'h600DD00D);
    chk("t5_term_noerr", req_err, 0);
    req_valid[0] = 1'b0;
    tick(1);

    // reset while waiting for done
    push(1, 1'b1, 32'h60000840, 32'h00000001, 1'b0, '0);
    req(1, 1'b1, 32'h60000840, 32'h00000001);
    serve(-1, '0);
    tick(2);
    reset = 1'b1;
    #1;
    check_zero("t6_rst");
    void'(exp_cp.pop_back());
    req_valid = '0;
    tick(1);
    reset = 1'b0;
    ipic_done_lite_wire = 1'b1;
    tick(1);
    ipic_done_lite_wire = 1'b0;
    chk("t6_ign", {req_done, req_err, busy}, 0);
    tick(1);
    chk("t6_ign2", {req_done, req_err, busy}, 0);
    // pointer is back at 0: requester 0 beats requester 3
    push(0, 1'b1, 32'h60000850, 32'h0000AAAA, 1'b0, '0);
    push(3, 1'b1, 32'h60000854, 32'h0000BBBB, 1'b0, '0);
    req(0, 1'b1, 32'h60000850, 32'h0000AAAA);
    req(3, 1'b1, 32'h60000854, 32'h0000BBBB);
    tick(1);
    chk("t6_gnt0", req_grant, 4'b0001);
    serve(1, '0);
    req_valid[0] = 1'b0;
    serve(1, '0);
    req_valid[3] = 1'b0;
    tick(3);

    chk("q_st_empty", exp_st.size(), 0);
    chk("q_cp_empty", exp_cp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
